// File: rtl/irq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : irq_ctrl
// Purpose  : Fixed-priority interrupt controller with a small bus-mapped
//            register file (PENDING / MASK / STATUS) and an IDLE/REQ/CLR
//            handshake towards the CPU.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk, rst_n        clock (rising edge), asynchronous active-low reset
//   src[NUM_IRQ]      interrupt sources from peripherals
//   src_clr[NUM_IRQ]  one-cycle clear pulse back to the serviced source
//   irq_req, irq_vec  request and winning source index towards the CPU
//   irq_ack           CPU acceptance of irq_req
//   addr, din,
//   wr_en, rd_en      data/IO bus
//   dout, hit         registered read data and its valid flag
// Registers (BASE_ADDR + n)
//   +0 PENDING  read, write-1-to-clear (edge mode only)
//   +1 MASK     read/write
//   +2 STATUS   read-only: bit7 in-service, bits[2:0] irq_vec
// Configuration
//   IRQ_CTRL_EDGE_EN  defined  : PENDING latches rising edges of src
//                     undefined: PENDING follows registered src (level mode)
// ============================================================================
module irq_ctrl #(
  parameter int unsigned NUM_IRQ   = 4,
  parameter logic [7:0]  BASE_ADDR = 8'h10
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_IRQ-1:0] src,
  output logic [NUM_IRQ-1:0] src_clr,
  output logic               irq_req,
  output logic [2:0]         irq_vec,
  input  logic               irq_ack,
  input  logic [7:0]         addr,
  input  logic [7:0]         din,
  input  logic               wr_en,
  input  logic               rd_en,
  output logic [7:0]         dout,
  output logic               hit
);

  localparam logic [7:0] c_addr_pend = BASE_ADDR;
  localparam logic [7:0] c_addr_mask = BASE_ADDR + 8'd1;
  localparam logic [7:0] c_addr_stat = BASE_ADDR + 8'd2;
  // Implemented bit positions; everything above NUM_IRQ stays 0.
  localparam logic [7:0] c_valid     = 8'((9'd1 << NUM_IRQ) - 9'd1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    CLR  = 2'd2
  } state_t;

  state_t     r_state;
  // Kept 8 bits wide so bus reads need no padding; unused bits hold 0.
  logic [7:0] r_pend;
  logic [7:0] r_mask;

  logic [7:0] w_act;
  logic [2:0] w_win;
  logic [7:0] w_vec_oh;
  logic [7:0] w_clr8;
  logic [7:0] w_pend_nxt;
  logic [7:0] w_mask_nxt;
  logic       w_wr_mask;
  logic       w_withdraw;

  assign w_act     = r_pend & r_mask;
  assign w_wr_mask = wr_en && (addr == c_addr_mask);

  // Lowest active index wins.
  always_comb begin
    w_win = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (w_act[i]) w_win = 3'(i);
    end
  end

  generate
    for (genvar g = 0; g < 8; g++) begin : g_vec_oh
      assign w_vec_oh[g] = (irq_vec == 3'(g));
    end
  endgenerate

  // Bit being serviced is cleared on the CLR -> IDLE edge.
  assign w_clr8 = (r_state == CLR) ? w_vec_oh : 8'h00;

`ifdef IRQ_CTRL_EDGE_EN
  logic [NUM_IRQ-1:0] r_src_q;
  logic [7:0]         w_rise;
  logic [7:0]         w_w1c;

  assign w_rise = 8'(src & ~r_src_q);
  assign w_w1c  = (wr_en && (addr == c_addr_pend)) ? (din & c_valid) : 8'h00;
  // A new rising edge overrides both W1C and the CLR clear.
  assign w_pend_nxt = (r_pend & ~w_w1c & ~w_clr8) | w_rise;
`else
  // Level mode: PENDING mirrors src one cycle late; W1C is ignored.
  assign w_pend_nxt = 8'(src) & ~w_clr8;
`endif

  assign w_mask_nxt = w_wr_mask ? (din & c_valid) : r_mask;

  // Looking at next-cycle PENDING/MASK lets irq_req drop in the cycle right
  // after the withdrawing write instead of one cycle later.
  assign w_withdraw = ~|(w_pend_nxt & w_mask_nxt & w_vec_oh);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_pend  <= 8'h00;
      r_mask  <= 8'h00;
      irq_req <= 1'b0;
      irq_vec <= 3'd0;
      src_clr <= '0;
      dout    <= 8'h00;
      hit     <= 1'b0;
`ifdef IRQ_CTRL_EDGE_EN
      r_src_q <= '0;
`endif
    end else begin
`ifdef IRQ_CTRL_EDGE_EN
      r_src_q <= src;
`endif
      r_pend  <= w_pend_nxt;
      r_mask  <= w_mask_nxt;
      src_clr <= '0;

      case (r_state)
        IDLE: begin
          irq_req <= 1'b0;
          if (|w_act) begin
            r_state <= REQ;
            irq_vec <= w_win;
            irq_req <= 1'b1;
          end
        end
        REQ: begin
          // irq_ack takes precedence over a simultaneous withdrawal.
          if (irq_ack) begin
            r_state <= CLR;
            irq_req <= 1'b0;
            src_clr <= w_vec_oh[NUM_IRQ-1:0];
          end else if (w_withdraw) begin
            r_state <= IDLE;
            irq_req <= 1'b0;
          end
        end
        CLR: begin
          r_state <= IDLE;
          irq_req <= 1'b0;
        end
        default: begin
          r_state <= IDLE;
          irq_req <= 1'b0;
        end
      endcase

      dout <= 8'h00;
      hit  <= 1'b0;
      if (rd_en) begin
        if (addr == c_addr_pend) begin
          dout <= r_pend;
          hit  <= 1'b1;
        end else if (addr == c_addr_mask) begin
          dout <= r_mask;
          hit  <= 1'b1;
        end else if (addr == c_addr_stat) begin
          dout <= {(r_state == CLR), 4'b0000, irq_vec};
          hit  <= 1'b1;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_irq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_irq_ctrl
// Purpose  : Self-checking bench for irq_ctrl. Sources are driven by a
//            peripheral model that holds a raised bit until it sees its
//            src_clr pulse; expected service order comes from the priority
//            rule applied to the raised/masked source sets.
// Revision : 1.0 - initial release
// ============================================================================
module tb_irq_ctrl;

  localparam int unsigned NUM_IRQ   = 4;
  localparam logic [7:0]  BASE_ADDR = 8'h10;
  localparam logic [7:0]  A_PEND    = BASE_ADDR;
  localparam logic [7:0]  A_MASK    = BASE_ADDR + 8'd1;
  localparam logic [7:0]  A_STAT    = BASE_ADDR + 8'd2;

  logic               clk;
  logic               rst_n;
  logic [NUM_IRQ-1:0] src;
  logic [NUM_IRQ-1:0] src_clr;
  logic               irq_req;
  logic [2:0]         irq_vec;
  logic               irq_ack;
  logic [7:0]         addr;
  logic [7:0]         din;
  logic               wr_en;
  logic               rd_en;
  logic [7:0]         dout;
  logic               hit;

  int n_checks = 0;
  int n_fail   = 0;
  int clr_pulses = 0;
  logic [NUM_IRQ-1:0] prev_clr = '0;

  irq_ctrl #(.NUM_IRQ(NUM_IRQ), .BASE_ADDR(BASE_ADDR)) dut (
    .clk(clk), .rst_n(rst_n), .src(src), .src_clr(src_clr),
    .irq_req(irq_req), .irq_vec(irq_vec), .irq_ack(irq_ack),
    .addr(addr), .din(din), .wr_en(wr_en), .rd_en(rd_en),
    .dout(dout), .hit(hit)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // One clock; sample 1 ns after the edge and let the peripheral react.
  task automatic tick();
    @(posedge clk);
    #1;
    if (src_clr != '0) begin
      chk("clr_width", 32'(prev_clr), 32'd0);
      chk("clr_onehot", $countones(src_clr), 1);
      if (prev_clr == '0) clr_pulses++;
      src = src & ~src_clr;
    end
    prev_clr = src_clr;
  endtask

  task automatic bus_write(input logic [7:0] a, input logic [7:0] d);
    addr = a; din = d; wr_en = 1'b1;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic bus_read(input logic [7:0] a, output logic [7:0] d, output logic h);
    addr = a; rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    d = dout;
    h = hit;
  endtask

  task automatic wait_req(input int max_cyc, output int cyc);
    cyc = 0;
    while (!irq_req && cyc < max_cyc) begin
      tick();
      cyc++;
    end
  endtask

  // Wait for a request, hold it ack_dly cycles, acknowledge, check the pulse.
  task automatic serve(input int exp_vec, input int ack_dly);
    int cyc;
    wait_req(8, cyc);
    chk("svc_req", 32'(irq_req), 32'd1);
    chk("svc_vec", 32'(irq_vec), 32'(exp_vec));
    for (int k = 0; k < ack_dly; k++) begin
      tick();
      chk("svc_vec_hold", 32'(irq_vec), 32'(exp_vec));
    end
    irq_ack = 1'b1;
    tick();
    irq_ack = 1'b0;
    chk("svc_clr", 32'(src_clr), 32'd1 << exp_vec);
    chk("svc_req_drop", 32'(irq_req), 32'd0);
  endtask

  task automatic cleanup();
    src = '0;
    bus_write(A_MASK, 8'h00);
    bus_write(A_PEND, 8'hFF);
    tick();
    tick();
  endtask

  initial begin
    logic [7:0] d;
    logic       h;
    int         cyc;
    int         pulses0;
    logic [3:0] s, m;

    rst_n = 1'b0; src = '0; irq_ack = 1'b0;
    addr = 8'h00; din = 8'h00; wr_en = 1'b0; rd_en = 1'b0;
    tick();
    tick();
    chk("rst_req", 32'(irq_req), 32'd0);
    chk("rst_vec", 32'(irq_vec), 32'd0);
    chk("rst_clr", 32'(src_clr), 32'd0);
    chk("rst_dout", 32'(dout), 32'd0);
    chk("rst_hit", 32'(hit), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    bus_read(A_MASK, d, h);
    chk("rst_mask", 32'(d), 32'h00);

    // Register access, read latency and undecoded address.
    bus_write(A_MASK, 8'hFF);
    bus_read(A_MASK, d, h);
    chk("mask_rd_dout", 32'(d), 32'h0F);
    chk("mask_rd_hit", 32'(h), 32'd1);
    tick();
    chk("mask_rd_hit_1cyc", 32'(hit), 32'd0);
    chk("mask_rd_dout_1cyc", 32'(dout), 32'd0);
    bus_read(BASE_ADDR + 8'd3, d, h);
    chk("undec_hit", 32'(h), 32'd0);
    chk("undec_dout", 32'(d), 32'd0);
    bus_read(A_STAT, d, h);
    chk("stat_idle", 32'(d), 32'h00);

    // Single source: request within 2 cycles, one clear pulse, in-service.
    src = 4'b0100;
    wait_req(2, cyc);
    chk("single_req", 32'(irq_req), 32'd1);
    chk("single_vec", 32'(irq_vec), 32'd2);
    pulses0 = clr_pulses;
    irq_ack = 1'b1;
    tick();
    irq_ack = 1'b0;
    chk("single_clr", 32'(src_clr), 32'b0100);
    bus_read(A_STAT, d, h);
    chk("single_stat_insvc", 32'(d), 32'h82);
    chk("single_clr_gone", 32'(src_clr), 32'd0);
    bus_read(A_PEND, d, h);
    chk("single_pend_zero", 32'(d), 32'h00);
    chk("single_pulses", 32'(clr_pulses - pulses0), 32'd1);

    // Two simultaneous sources: lower index first, one IDLE cycle between.
    src = 4'b1010;
    serve(1, 0);
    wait_req(6, cyc);
    chk("pair_gap", 32'(cyc), 32'd2);
    serve(3, 1);
    tick();

    // Withdrawal by mask write, then the same write racing an ack.
    src = 4'b0001;
    wait_req(4, cyc);
    chk("wd_vec", 32'(irq_vec), 32'd0);
    pulses0 = clr_pulses;
    bus_write(A_MASK, 8'h00);
    chk("wd_req_drop", 32'(irq_req), 32'd0);
    tick();
    tick();
    chk("wd_no_clr", 32'(clr_pulses - pulses0), 32'd0);
    bus_write(A_MASK, 8'h0F);
    wait_req(4, cyc);
    chk("wd_rereq", 32'(irq_req), 32'd1);
    addr = A_MASK; din = 8'h00; wr_en = 1'b1; irq_ack = 1'b1;
    tick();
    wr_en = 1'b0; irq_ack = 1'b0;
    chk("wd_ack_wins", 32'(src_clr), 32'b0001);
    cleanup();

    // Acknowledge outside REQ has no effect.
    pulses0 = clr_pulses;
    bus_write(A_MASK, 8'h0F);
    irq_ack = 1'b1;
    tick(); tick(); tick();
    irq_ack = 1'b0;
    chk("ack_idle_clr", 32'(clr_pulses - pulses0), 32'd0);
    chk("ack_idle_req", 32'(irq_req), 32'd0);
    cleanup();

    // Randomized rounds: raise a random set under a random mask; masked-in
    // sources are serviced in ascending index order, the rest stay pending.
    for (int r = 0; r < 10; r++) begin
      m = 4'($urandom_range(0, 15));
      s = 4'($urandom_range(1, 15));
      bus_write(A_MASK, {4'h0, m});
      src = s;
      for (int i = 0; i < 4; i++) begin
        if (s[i] && m[i]) serve(i, int'($urandom_range(0, 3)));
      end
      tick(); tick(); tick();
      chk("rnd_no_extra_req", 32'(irq_req), 32'd0);
      bus_read(A_PEND, d, h);
      chk("rnd_pend_left", 32'(d), 32'(s & ~m));
      cleanup();
    end

`ifdef IRQ_CTRL_EDGE_EN
    // Edge mode: latch on rising edge, set beats a same-cycle W1C.
    src = 4'b0001;
    tick(); tick();
    src = 4'b0000;
    tick();
    bus_read(A_PEND, d, h);
    chk("edge_latch", 32'(d), 32'h01);
    src = 4'b0001;
    addr = A_PEND; din = 8'h01; wr_en = 1'b1;
    tick();
    wr_en = 1'b0;
    bus_read(A_PEND, d, h);
    chk("edge_set_beats_w1c", 32'(d), 32'h01);
    bus_write(A_PEND, 8'h01);
    bus_read(A_PEND, d, h);
    chk("edge_w1c_clear", 32'(d), 32'h00);
`else
    // Level mode: PENDING follows src and ignores W1C.
    src = 4'b0001;
    tick();
    bus_write(A_PEND, 8'h01);
    bus_read(A_PEND, d, h);
    chk("level_w1c_ignored", 32'(d), 32'h01);
    src = 4'b0000;
    tick(); tick();
    bus_read(A_PEND, d, h);
    chk("level_follow", 32'(d), 32'h00);
`endif
    cleanup();

    // Reset in the middle of a request.
    bus_write(A_MASK, 8'h0F);
    src = 4'b0100;
    wait_req(4, cyc);
    chk("mr_req", 32'(irq_req), 32'd1);
    addr = A_STAT; rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    chk("mr_stat_hit", 32'(hit), 32'd1);
    chk("mr_stat", 32'(dout), 32'h02);
    pulses0 = clr_pulses;
    rst_n = 1'b0;
    #2;
    chk("mr_req_low", 32'(irq_req), 32'd0);
    chk("mr_vec_low", 32'(irq_vec), 32'd0);
    chk("mr_clr_low", 32'(src_clr), 32'd0);
    chk("mr_dout_low", 32'(dout), 32'd0);
    chk("mr_hit_low", 32'(hit), 32'd0);
    tick(); tick();
    @(negedge clk);
    rst_n = 1'b1;
    tick(); tick();
    chk("mr_no_clr", 32'(clr_pulses - pulses0), 32'd0);
    chk("mr_req_after", 32'(irq_req), 32'd0);
    bus_read(A_MASK, d, h);
    chk("mr_mask_zero", 32'(d), 32'h00);
    src = '0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
